// File: rtl/hotspot_traffic_gen_pkg.sv
// Shared definitions for the hotspot traffic generator.
// Covers the flit layout, FSM state encoding, LFSR seed/taps and the
// helper functions used by both the generator and its LFSR.
package hotspot_traffic_gen_pkg;

    // Flit layout: {src[19:16], seq[15:4], dest[3:0]}
    localparam int FLIT_W   = 20;
    localparam int SRC_MSB  = 19;
    localparam int SRC_LSB  = 16;
    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 4;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 0;
    localparam int SEQ_W    = SEQ_MSB - SEQ_LSB + 1;
    localparam int NODE_W   = SRC_MSB - SRC_LSB + 1;

    // Fallback seed, used when a zero seed is requested (zero locks up an LFSR).
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
    // The feedback taps are state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One LFSR step: the XOR of the tapped bits enters at the top.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    // Destination choice from an already-advanced LFSR value.
    // The low byte decides hotspot vs. uniform traffic.
    // The uniform pick never targets the source itself.
    function automatic logic [NODE_W-1:0] pick_dest(
        input logic [15:0]       lfsr,
        input logic [NODE_W-1:0] src,
        input logic [NODE_W-1:0] hot,
        input logic [7:0]        thr
    );
        logic [NODE_W-1:0] dest;
        if (lfsr[7:0] < thr) begin
            dest = hot;
        end else if (lfsr[11:8] == src) begin
            dest = src + 4'd1;
        end else begin
            dest = lfsr[11:8];
        end
        return dest;
    endfunction

    // Pack the three flit fields.
    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [NODE_W-1:0] src,
        input logic [SEQ_W-1:0]  seq,
        input logic [NODE_W-1:0] dest
    );
        return {src, seq, dest};
    endfunction

endpackage

// File: rtl/hotspot_traffic_gen_lfsr16.sv
// 16-bit maximal-length LFSR.
// The register steps once per cycle while adv is high.
// A zero seed is replaced by the package default so the register can never lock up.
module lfsr16
    import hotspot_traffic_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    localparam logic [15:0] RESET_VALUE = (SEED == 16'd0) ? DEFAULT_LFSR_SEED : SEED;

    logic [15:0] state_r;

    // LFSR register: seeded by reset, stepped only on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RESET_VALUE;
        end else if (adv) begin
            state_r <= lfsr_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/hotspot_traffic_gen.sv
// Hotspot traffic generator.
// On start it emits NUM_FLITS flits with INJ_GAP idle cycles between them.
// A fraction HOTSPOT_THR/256 of the flits targets HOTSPOT_ID; the rest
// target LFSR-chosen nodes and never this node itself.
// The flow control is valid/ready. All outputs are registered.
module hotspot_traffic_gen
    import hotspot_traffic_gen_pkg::*;
#(
    parameter logic [3:0]  SRC_ID      = 4'd0,
    parameter logic [3:0]  HOTSPOT_ID  = 4'd5,
    parameter logic [7:0]  HOTSPOT_THR = 8'd128,
    parameter logic [7:0]  INJ_GAP     = 8'd2,
    parameter logic [15:0] NUM_FLITS   = 16'd64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sent_count
);

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         gap_cnt_r;
    logic [7:0]         gap_cnt_s;
    logic [SEQ_W-1:0]   seq_r;
    logic [SEQ_W-1:0]   seq_s;
    logic [SEQ_W-1:0]   load_seq_s;
    logic [15:0]        sent_r;
    logic [15:0]        sent_s;
    logic [FLIT_W-1:0]  flit_r;
    logic [FLIT_W-1:0]  flit_s;
    logic               valid_r;
    logic               valid_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic               load_s;
    logic               accept_s;
    logic               last_s;
    logic [15:0]        lfsr_state_s;
    logic [15:0]        lfsr_adv_s;
    logic [NODE_W-1:0]  dest_s;

    // The LFSR steps on each flit load.
    // The destination is taken from the value the LFSR is about to hold,
    // so one load means exactly one step.
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (load_s),
        .state (lfsr_state_s)
    );

    assign lfsr_adv_s = lfsr_next(lfsr_state_s);
    assign dest_s     = pick_dest(lfsr_adv_s, SRC_ID, HOTSPOT_ID, HOTSPOT_THR);
    assign accept_s   = valid_r & out_ready;
    assign last_s     = (sent_r == (NUM_FLITS - 16'd1));

    // Next-state and next-output logic for the run sequencer
    always_comb begin
        state_s    = state_r;
        gap_cnt_s  = gap_cnt_r;
        seq_s      = seq_r;
        sent_s     = sent_r;
        load_s     = 1'b0;
        load_seq_s = seq_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sent_s     = 16'd0;
                    seq_s      = 12'd0;
                    load_seq_s = 12'd0;
                    gap_cnt_s  = 8'd0;
                    if (INJ_GAP == 8'd0) begin
                        state_s = ST_SEND;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            // GAP lasts exactly INJ_GAP cycles; the counter starts at 0 on entry
            ST_GAP: begin
                if (gap_cnt_r == (INJ_GAP - 8'd1)) begin
                    gap_cnt_s = 8'd0;
                    state_s   = ST_SEND;
                    load_s    = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                end
            end

            // Hold the flit until it is accepted; start is ignored while busy
            ST_SEND: begin
                if (accept_s) begin
                    sent_s     = sent_r + 16'd1;
                    seq_s      = seq_r + 12'd1;
                    load_seq_s = seq_r + 12'd1;
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else if (INJ_GAP == 8'd0) begin
                        state_s = ST_SEND;
                        load_s  = 1'b1;
                    end else begin
                        state_s   = ST_GAP;
                        gap_cnt_s = 8'd0;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (load_s) begin
            flit_s = make_flit(SRC_ID, load_seq_s, dest_s);
        end else begin
            flit_s = flit_r;
        end

        valid_s = (state_s == ST_SEND);
        busy_s  = (state_s == ST_GAP) || (state_s == ST_SEND);
        done_s  = (state_s == ST_DONE);
    end

    // State register and registered outputs; reset drops everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
            seq_r     <= 12'd0;
            sent_r    <= 16'd0;
            flit_r    <= 20'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            seq_r     <= seq_s;
            sent_r    <= sent_s;
            flit_r    <= flit_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign out_valid  = valid_r;
    assign dataout    = flit_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sent_count = sent_r;

endmodule

// File: tb/tb_hotspot_traffic_gen.sv
// Scoreboard bench for hotspot_traffic_gen with two instances.
// Instance A: INJ_GAP=2, NUM_FLITS=4. It covers timing, restart, ignored start and mid-run reset.
// Instance B: INJ_GAP=0, NUM_FLITS=4097, zero seed. It covers stall hold, random backpressure, sequence wrap and statistics.
module tb_hotspot_traffic_gen;

    localparam logic [3:0]  A_SRC  = 4'd0;
    localparam logic [3:0]  A_HOT  = 4'd5;
    localparam logic [7:0]  A_THR  = 8'd128;
    localparam logic [7:0]  A_GAP  = 8'd2;
    localparam logic [15:0] A_N    = 16'd4;
    localparam logic [15:0] A_SEED = 16'h1234;

    localparam logic [3:0]  B_SRC  = 4'd3;
    localparam logic [3:0]  B_HOT  = 4'd9;
    localparam logic [7:0]  B_THR  = 8'd128;
    localparam logic [7:0]  B_GAP  = 8'd0;
    localparam logic [15:0] B_N    = 16'd4097;
    localparam logic [15:0] B_SEED = 16'h0000;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic        a_rst, a_start, a_ready, a_valid, a_busy, a_done;
    logic [19:0] a_data;
    logic [15:0] a_cnt;
    logic        b_rst, b_start, b_ready, b_valid, b_busy, b_done;
    logic [19:0] b_data;
    logic [15:0] b_cnt;

    hotspot_traffic_gen #(
        .SRC_ID(A_SRC), .HOTSPOT_ID(A_HOT), .HOTSPOT_THR(A_THR),
        .INJ_GAP(A_GAP), .NUM_FLITS(A_N), .LFSR_SEED(A_SEED)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .out_ready(a_ready),
        .out_valid(a_valid), .dataout(a_data), .busy(a_busy), .done(a_done),
        .sent_count(a_cnt)
    );

    hotspot_traffic_gen #(
        .SRC_ID(B_SRC), .HOTSPOT_ID(B_HOT), .HOTSPOT_THR(B_THR),
        .INJ_GAP(B_GAP), .NUM_FLITS(B_N), .LFSR_SEED(B_SEED)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .out_ready(b_ready),
        .out_valid(b_valid), .dataout(b_data), .busy(b_busy), .done(b_done),
        .sent_count(b_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model. The LFSR is defined by the exponents of x^16+x^14+x^13+x^11+1.
    // The register shifts right; the new top bit is the XOR of the
    // state bits at positions 16-e for each exponent e.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        int  exps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        for (int k = 0; k < 4; k++) fb ^= s[16 - exps[k]];
        return {fb, s[15:1]};
    endfunction

    function automatic int ref_dest(input logic [15:0] l, input int src, input int hot, input int thr);
        int lo = int'(l[7:0]);
        int hi = int'(l[11:8]);
        if (lo < thr) return hot;
        if (hi == src) return (src + 1) % 16;
        return hi;
    endfunction

    logic [19:0] a_exp [$];
    logic [19:0] b_exp [$];
    logic [15:0] a_lfsr;
    logic [15:0] b_lfsr;
    int          a_vcyc [$];
    int          a_t0 = 0;
    int          b_idx = 0;
    int          b_hot = 0;

    task automatic push_run_a();
        for (int i = 0; i < int'(A_N); i++) begin
            int d;
            a_lfsr = ref_step(a_lfsr);
            d = ref_dest(a_lfsr, int'(A_SRC), int'(A_HOT), int'(A_THR));
            a_exp.push_back({A_SRC, 12'(i % 4096), 4'(d)});
        end
    endtask

    task automatic push_run_b();
        for (int i = 0; i < int'(B_N); i++) begin
            int d;
            b_lfsr = ref_step(b_lfsr);
            d = ref_dest(b_lfsr, int'(B_SRC), int'(B_HOT), int'(B_THR));
            b_exp.push_back({B_SRC, 12'(i % 4096), 4'(d)});
        end
    endtask

    task automatic wait_a_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (a_done) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_a_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_data"},  32'(a_data),  32'd0);
        check({tag, "_busy"},  32'(a_busy),  32'd0);
        check({tag, "_done"},  32'(a_done),  32'd0);
        check({tag, "_count"}, 32'(a_cnt),   32'd0);
    endtask

    // Monitor A: records the cycles with out_valid high and scores accepted flits
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (a_rst && a_valid) a_vcyc.push_back(cyc - a_t0);
            if (a_rst && a_valid && a_ready) begin
                if (a_exp.size() == 0) begin
                    check("a_unexpected_flit", 32'(a_data), 32'hFFFFFFFF);
                end else begin
                    e = a_exp.pop_front();
                    check("a_flit", 32'(a_data), 32'(e));
                end
            end
        end
    end

    // Monitor B: stall stability, flit scoreboard, field rules and hotspot tally
    initial begin
        logic [19:0] e;
        logic        stall_prev;
        logic [19:0] prev;
        stall_prev = 1'b0;
        prev = 20'd0;
        forever begin
            @(negedge clk);
            if (!b_rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("b_valid_held", 32'(b_valid), 32'd1);
                    check("b_data_held",  32'(b_data),  32'(prev));
                end
                if (b_valid && b_ready) begin
                    if (b_exp.size() == 0) begin
                        check("b_unexpected_flit", 32'(b_data), 32'hFFFFFFFF);
                    end else begin
                        e = b_exp.pop_front();
                        check("b_flit", 32'(b_data), 32'(e));
                    end
                    check("b_src_field", 32'(b_data[19:16]), 32'(B_SRC));
                    check("b_dest_is_src", 32'(b_data[3:0] == B_SRC), 32'd0);
                    if (b_data[3:0] == B_HOT) b_hot++;
                    if (b_idx == 4095) check("b_seq_max",  32'(b_data[15:4]), 32'hFFF);
                    if (b_idx == 4096) check("b_seq_wrap", 32'(b_data[15:4]), 32'd0);
                    b_idx++;
                end
                stall_prev = b_valid && !b_ready;
                prev = b_data;
            end
        end
    end

    // Watchdog: guarantees the run ends even if the DUT stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        bit found;
        int lo_lim, hi_lim, b_t0;
        a_rst = 1'b0; a_start = 1'b0; a_ready = 1'b1;
        b_rst = 1'b0; b_start = 1'b0; b_ready = 1'b0;
        a_lfsr = A_SEED;
        b_lfsr = (B_SEED == 16'd0) ? 16'hACE1 : B_SEED;

        repeat (3) @(posedge clk);
        #1;
        check_a_reset_outputs("a_in_reset");
        check("b_in_reset_valid", 32'(b_valid), 32'd0);
        check("b_in_reset_data",  32'(b_data),  32'd0);
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        check_a_reset_outputs("a_after_release");

        // Run A1: gap timing; a start pulse while busy is ignored
        a_vcyc.delete();
        push_run_a();
        a_t0 = cyc;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("a1_busy_before_pulse", 32'(a_busy), 32'd1);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_a_done(50);
        check("a1_done_cycle", 32'(cyc - a_t0), 32'd13);
        check("a1_sent_count", 32'(a_cnt), 32'd4);
        check("a1_valid_cycles", 32'(a_vcyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < a_vcyc.size(); i++)
            check("a1_valid_cycle_k", 32'(a_vcyc[i]), 32'(3 * (i + 1)));
        check("a1_queue_empty", 32'(a_exp.size()), 32'd0);

        // done holds, then a start in DONE restarts; the LFSR keeps running
        repeat (3) @(posedge clk);
        #1;
        check("a_done_holds", 32'(a_done), 32'd1);
        push_run_a();
        a_t0 = cyc;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check("a2_done_cleared", 32'(a_done), 32'd0);
        check("a2_busy_set", 32'(a_busy), 32'd1);
        wait_a_done(60);
        check("a2_done", 32'(a_done), 32'd1);
        check("a2_sent_count", 32'(a_cnt), 32'd4);
        check("a2_queue_empty", 32'(a_exp.size()), 32'd0);

        // Run A3: reset while flit 2 is valid
        push_run_a();
        a_t0 = cyc;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_valid && a_data[15:4] == 12'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("a3_flit2_seen", 32'(found), 32'd1);
        #1;
        a_rst = 1'b0;
        #1;
        check_a_reset_outputs("a3_async_reset");
        a_exp.delete();
        a_lfsr = A_SEED;
        @(negedge clk);
        a_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("a3_no_resume_valid", 32'(a_valid), 32'd0);
            check("a3_no_resume_busy",  32'(a_busy),  32'd0);
        end

        // Run A4: must replay the first run's flits from the seed
        push_run_a();
        a_t0 = cyc;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_a_done(60);
        check("a4_done", 32'(a_done), 32'd1);
        check("a4_sent_count", 32'(a_cnt), 32'd4);
        check("a4_queue_empty", 32'(a_exp.size()), 32'd0);

        // Run B: stall with out_ready low for 5 cycles, then random backpressure
        push_run_b();
        b_t0 = cyc;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (b_valid) break;
            @(posedge clk); #1;
        end
        check("b_first_valid_latency", 32'(cyc - b_t0), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("b_stall_valid", 32'(b_valid), 32'd1);
            if (b_exp.size() > 0) check("b_stall_data", 32'(b_data), 32'(b_exp[0]));
            check("b_stall_count", 32'(b_cnt), 32'd0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 20000 && !b_done; k++) begin
            b_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        b_ready = 1'b1;
        check("b_done", 32'(b_done), 32'd1);
        check("b_sent_count", 32'(b_cnt), 32'd4097);
        check("b_flits_seen", 32'(b_idx), 32'd4097);
        check("b_queue_empty", 32'(b_exp.size()), 32'd0);
        // dest==HOTSPOT_ID also catches uniform picks that land on node 9
        // (1/16 of the non-hotspot half), so centre at 53.1% with a +/-3% band.
        lo_lim = (4097 * 501) / 1000;
        hi_lim = (4097 * 561) / 1000;
        check("b_hotspot_fraction_in_window", 32'(b_hot >= lo_lim && b_hot <= hi_lim), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
